// File: rtl/parameterized_reg_file_reader.sv
// Streams a contiguous, wrapping range of register-file words out over a
// valid/ready port, fetching two words per refill through a 2-entry buffer.
module parameterized_reg_file_reader #(
  parameter int WIDTH         = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int ADR_BUS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADR_BUS_WIDTH-1:0] base_addr,
  input  logic [ADR_BUS_WIDTH:0]   count,
  output logic [ADR_BUS_WIDTH-1:0] raddress0,
  output logic [ADR_BUS_WIDTH-1:0] raddress1,
  input  logic [WIDTH-1:0]         rdata0,
  input  logic [WIDTH-1:0]         rdata1,
  output logic [WIDTH-1:0]         m_data,
  output logic [ADR_BUS_WIDTH-1:0] m_addr,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int AW = ADR_BUS_WIDTH;
  localparam logic [AW:0] NREG = (AW+1)'(NUM_REGISTERS);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] TWO  = (AW+1)'(2);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  ptr_q;
  logic [AW:0]    rem_q;
  logic [1:0]     cnt_q;
  logic [WIDTH-1:0] d0_q, d1_q;
  logic [AW-1:0]  a0_q, a1_q;
  logic           l0_q, l1_q;
  logic           err_q;

  logic           pop;
  logic           req_ok;
  logic           accept;
  logic           fetch;
  logic           one;
  logic [AW:0]    take;
  logic [AW-1:0]  ptr_p1;
  logic [AW-1:0]  ptr_adv;

  function automatic logic [AW-1:0] wrap_add(
    input logic [AW-1:0] p,
    input logic [AW:0]   k
  );
    logic [AW:0] s;
    s = {1'b0, p} + k;
    if (s >= NREG) s = s - NREG;
    return s[AW-1:0];
  endfunction

  assign m_valid = (cnt_q != 2'd0);
  assign pop     = m_valid && m_ready;
  assign req_ok  = (count != '0) && (count <= NREG);
  assign accept  = (state_q == IDLE) && start && req_ok;
  assign one     = (rem_q == ONE);
  assign take    = one ? ONE : TWO;
  assign ptr_p1  = wrap_add(ptr_q, ONE);
  assign ptr_adv = wrap_add(ptr_q, take);

  // Refill only once the buffer is empty or its final entry leaves now,
  // which keeps a one-beat-per-cycle stream without a deeper buffer.
  assign fetch = (state_q == FETCH) &&
                 ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = FETCH;
      FETCH: if (fetch && (rem_q <= TWO)) state_d = DRAIN;
      DRAIN: if (pop && m_last) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && start && !req_ok;
      if (accept) begin
        ptr_q <= base_addr;
        rem_q <= count;
      end else if (fetch) begin
        ptr_q <= ptr_adv;
        rem_q <= rem_q - take;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 2'd0;
      d0_q  <= '0;
      d1_q  <= '0;
      a0_q  <= '0;
      a1_q  <= '0;
      l0_q  <= 1'b0;
      l1_q  <= 1'b0;
    end else if (fetch) begin
      d0_q  <= rdata0;
      a0_q  <= ptr_q;
      l0_q  <= one;
      d1_q  <= rdata1;
      a1_q  <= ptr_p1;
      l1_q  <= (rem_q == TWO);
      cnt_q <= one ? 2'd1 : 2'd2;
    end else if (pop) begin
      if (cnt_q == 2'd2) begin
        d0_q  <= d1_q;
        a0_q  <= a1_q;
        l0_q  <= l1_q;
        cnt_q <= 2'd1;
      end else begin
        cnt_q <= 2'd0;
      end
    end
  end

  assign m_data    = d0_q;
  assign m_addr    = a0_q;
  assign m_last    = m_valid && l0_q;
  assign busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign raddress0 = (state_q == IDLE) ? '0 : ptr_q;
  assign raddress1 = (state_q == IDLE) ? '0 : ptr_p1;

endmodule

// File: tb/tb_parameterized_reg_file_reader.sv
// Scoreboard bench: expected beats queued at start, popped on handshakes.
// Two instances cover the 32x32 and 64x16 configurations.
module tb_parameterized_reg_file_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        start_a, mv_a, mr_a, ml_a, busy_a, done_a, err_a;
  logic [4:0]  base_a, ra0_a, ra1_a, ma_a;
  logic [5:0]  cnt_a;
  logic [31:0] rd0_a, rd1_a, md_a;

  logic        start_b, mv_b, mr_b, ml_b, busy_b, done_b, err_b;
  logic [3:0]  base_b, ra0_b, ra1_b, ma_b;
  logic [4:0]  cnt_b;
  logic [63:0] rd0_b, rd1_b, md_b;

  logic [31:0] regs_a [32];
  logic [63:0] regs_b [16];

  assign rd0_a = regs_a[ra0_a];
  assign rd1_a = regs_a[ra1_a];
  assign rd0_b = regs_b[ra0_b];
  assign rd1_b = regs_b[ra1_b];

  parameterized_reg_file_reader #(
    .WIDTH(32), .NUM_REGISTERS(32), .ADR_BUS_WIDTH(5)
  ) u_a (
    .clk(clk), .reset(rst_n), .start(start_a),
    .base_addr(base_a), .count(cnt_a),
    .raddress0(ra0_a), .raddress1(ra1_a),
    .rdata0(rd0_a), .rdata1(rd1_a),
    .m_data(md_a), .m_addr(ma_a), .m_valid(mv_a),
    .m_ready(mr_a), .m_last(ml_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  parameterized_reg_file_reader #(
    .WIDTH(64), .NUM_REGISTERS(16), .ADR_BUS_WIDTH(4)
  ) u_b (
    .clk(clk), .reset(rst_n), .start(start_b),
    .base_addr(base_b), .count(cnt_b),
    .raddress0(ra0_b), .raddress1(ra1_b),
    .rdata0(rd0_b), .rdata1(rd1_b),
    .m_data(md_b), .m_addr(ma_b), .m_valid(mv_b),
    .m_ready(mr_b), .m_last(ml_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t q_a[$];
  beat_t q_b[$];
  bit rnd_a = 1'b0;
  bit rnd_b = 1'b0;
  int dn_a = 0;

  task automatic check(input string tag, input logic [69:0] got,
                       input logic [69:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    mr_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mr_a = rnd_a ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    mr_b = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mr_b = rnd_b ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    bit st;
    logic [69:0] hold, cur;
    beat_t e;
    st = 1'b0;
    hold = '0;
    forever begin
      @(negedge clk);
      cur = {ma_a, 32'h0, md_a, ml_a};
      if (rst_n) begin
        if (st) begin
          check("a_hold_valid", 70'(mv_a), 70'(1));
          check("a_hold_beat", cur, hold);
        end
        if (mv_a && mr_a) begin
          if (q_a.size() == 0) check("a_extra_beat", 70'(1), 70'(0));
          else begin
            e = q_a.pop_front();
            check("a_beat", cur, {e.a, e.d, e.l});
          end
        end
        st = mv_a && !mr_a;
        hold = cur;
      end else st = 1'b0;
      if (done_a) dn_a++;
    end
  end

  initial begin
    bit st;
    logic [69:0] hold, cur;
    beat_t e;
    st = 1'b0;
    hold = '0;
    forever begin
      @(negedge clk);
      cur = {1'b0, ma_b, md_b, ml_b};
      if (rst_n) begin
        if (st) begin
          check("b_hold_valid", 70'(mv_b), 70'(1));
          check("b_hold_beat", cur, hold);
        end
        if (mv_b && mr_b) begin
          if (q_b.size() == 0) check("b_extra_beat", 70'(1), 70'(0));
          else begin
            e = q_b.pop_front();
            check("b_beat", cur, {e.a, e.d, e.l});
          end
        end
        st = mv_b && !mr_b;
        hold = cur;
      end else st = 1'b0;
    end
  end

  task automatic push_a(input int base, input int cnt);
    beat_t b;
    for (int i = 0; i < cnt; i++) begin
      b.a = 5'((base + i) % 32);
      b.d = 64'(regs_a[b.a]);
      b.l = (i == cnt - 1);
      q_a.push_back(b);
    end
  endtask

  task automatic wait_done_a();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = done_a;
    end
    check("a_done_seen", 70'(seen), 70'(1));
    @(negedge clk);
    check("a_done_one_cycle", 70'({done_a, busy_a}), 70'(0));
    check("a_queue_drained", 70'(q_a.size()), 70'(0));
  endtask

  task automatic dump_a(input int base, input int cnt,
                        input bit timing, input bit poke);
    push_a(base, cnt);
    @(posedge clk);
    #1;
    start_a = 1'b1;
    base_a  = 5'(base);
    cnt_a   = 6'(cnt);
    @(posedge clk);
    #1;
    start_a = 1'b0;
    if (timing) begin
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        check("a_lat_valid", 70'(mv_a), 70'(k >= 2 && k <= 5));
        check("a_lat_busy", 70'(busy_a), 70'(k <= 5));
        check("a_lat_done", 70'(done_a), 70'(k == 6));
      end
      @(negedge clk);
      check("a_done_one_cycle", 70'({done_a, busy_a}), 70'(0));
      check("a_queue_drained", 70'(q_a.size()), 70'(0));
    end else begin
      if (poke) begin
        repeat (3) @(posedge clk);
        #1;
        check("a_busy_at_poke", 70'(busy_a), 70'(1));
        start_a = 1'b1;
        base_a  = 5'd0;
        cnt_a   = 6'd1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
      end
      wait_done_a();
    end
  endtask

  task automatic dump_b(input int base, input int cnt);
    beat_t b;
    bit seen;
    for (int i = 0; i < cnt; i++) begin
      b.a = 5'((base + i) % 16);
      b.d = regs_b[b.a[3:0]];
      b.l = (i == cnt - 1);
      q_b.push_back(b);
    end
    @(posedge clk);
    #1;
    start_b = 1'b1;
    base_b  = 4'(base);
    cnt_b   = 5'(cnt);
    @(posedge clk);
    #1;
    start_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = done_b;
    end
    check("b_done_seen", 70'(seen), 70'(1));
    @(negedge clk);
    check("b_done_one_cycle", 70'({done_b, busy_b}), 70'(0));
    check("b_queue_drained", 70'(q_b.size()), 70'(0));
  endtask

  task automatic err_a_req(input int cnt);
    @(posedge clk);
    #1;
    start_a = 1'b1;
    base_a  = 5'd3;
    cnt_a   = 6'(cnt);
    @(posedge clk);
    #1;
    start_a = 1'b0;
    @(negedge clk);
    check("a_err_pulse", 70'({err_a, mv_a, busy_a}), 70'(3'b100));
    @(negedge clk);
    check("a_err_clear", 70'({err_a, mv_a, busy_a}), 70'(3'b000));
  endtask

  task automatic err_b_req(input int cnt);
    @(posedge clk);
    #1;
    start_b = 1'b1;
    base_b  = 4'd2;
    cnt_b   = 5'(cnt);
    @(posedge clk);
    #1;
    start_b = 1'b0;
    @(negedge clk);
    check("b_err_pulse", 70'({err_b, mv_b, busy_b}), 70'(3'b100));
    @(negedge clk);
    check("b_err_clear", 70'({err_b, mv_b, busy_b}), 70'(3'b000));
  endtask

  initial begin
    int dn0;
    bit hit;
    for (int i = 0; i < 32; i++) regs_a[i] = 32'hA000_0000 + 32'(i * 32'h0101);
    regs_a[1] = 32'h256;
    regs_a[2] = 32'h23;
    regs_a[3] = 32'h4531;
    regs_a[4] = 32'h4567;
    for (int i = 0; i < 16; i++) regs_b[i] = {$urandom, $urandom};
    rst_n = 1'b0;
    start_a = 1'b0; base_a = '0; cnt_a = '0;
    start_b = 1'b0; base_b = '0; cnt_b = '0;
    #12;
    check("a_reset_out", 70'({mv_a, ml_a, busy_a, done_a, err_a}), 70'(0));
    check("a_reset_bus", 70'({md_a, ma_a, ra0_a, ra1_a}), 70'(0));
    check("b_reset_out", 70'({mv_b, ml_b, busy_b, done_b, err_b}), 70'(0));
    check("b_reset_bus", 70'({md_b, ma_b}), 70'(0));
    check("b_reset_raddr", 70'({ra0_b, ra1_b}), 70'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    dump_a(1, 4, 1'b1, 1'b0);
    dump_a(5, 3, 1'b0, 1'b0);
    dump_a(30, 4, 1'b0, 1'b0);
    dump_b(8, 16);
    err_a_req(0);
    err_a_req(33);
    err_b_req(0);
    err_b_req(17);

    rnd_a = 1'b1;
    dump_a(7, 32, 1'b0, 1'b1);
    rnd_a = 1'b0;
    rnd_b = 1'b1;
    dump_b(13, 11);
    rnd_b = 1'b0;

    push_a(0, 8);
    @(posedge clk);
    #1;
    start_a = 1'b1;
    base_a  = 5'd0;
    cnt_a   = 6'd8;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      #1;
      hit = (q_a.size() <= 6);
    end
    check("a_two_beats_seen", 70'(hit), 70'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("a_async_rst_out", 70'({mv_a, ml_a, busy_a, done_a}), 70'(0));
    check("a_async_rst_bus", 70'({md_a, ma_a, ra0_a, ra1_a}), 70'(0));
    q_a.delete();
    dn0 = dn_a;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("a_no_done_after_rst", 70'(dn_a), 70'(dn0));
    dump_a(0, 2, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parameterized_reg_file_reader.md
PARAMETERIZED_REG_FILE_READER -- requirements
Module: parameterized_reg_file_reader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, register data width in bits.
REQ-002 The block SHALL have parameter NUM_REGISTERS, default 32, number of registers in the attached register file.
REQ-003 The block SHALL have parameter ADR_BUS_WIDTH, default 5, register address width in bits.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: dump request, sampled in IDLE.
REQ-008 The block SHALL have port base_addr, input, ADR_BUS_WIDTH bits: first register to read.
REQ-009 The block SHALL have port count, input, ADR_BUS_WIDTH+1 bits: number of registers to read.
REQ-010 The block SHALL have port raddress0, output, ADR_BUS_WIDTH bits: register file read port 0 address.
REQ-011 The block SHALL have port raddress1, output, ADR_BUS_WIDTH bits: register file read port 1 address.
REQ-012 The block SHALL have port rdata0, input, WIDTH bits: combinational read data for raddress0.
REQ-013 The block SHALL have port rdata1, input, WIDTH bits: combinational read data for raddress1.
REQ-014 The block SHALL have port m_data, output, WIDTH bits: stream data.
REQ-015 The block SHALL have port m_addr, output, ADR_BUS_WIDTH bits: register index of m_data.
REQ-016 The block SHALL have ports m_valid (output), m_ready (input) and m_last (output), 1 bit each: stream handshake, with m_last marking the final beat.
REQ-017 The block SHALL have port busy, output, 1 bit: transfer in progress.
REQ-018 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-019 The block SHALL have port err, output, 1 bit: one-cycle pulse on an invalid request.

Function
REQ-020 The FSM SHALL use states IDLE, FETCH, DRAIN and DONE.
REQ-021 In IDLE, start=1 with 1<=count<=NUM_REGISTERS SHALL latch ptr=base_addr and remaining=count and move to FETCH; busy=1 from the next cycle.
REQ-022 In IDLE, start=1 with count=0 or count>NUM_REGISTERS SHALL pulse err for one cycle, remain in IDLE and produce no beats.
REQ-023 The block SHALL ignore start while busy=1.
REQ-024 When the 2-entry output buffer is empty (or its last entry pops that cycle), FETCH SHALL drive raddress0=ptr and raddress1=(ptr+1) mod NUM_REGISTERS, then capture rdata0 and rdata1 on the clock edge.
REQ-025 When remaining=1, FETCH SHALL capture only rdata0.
REQ-026 After each fetch, ptr SHALL advance by the number of words captured, modulo NUM_REGISTERS (wrap NUM_REGISTERS-1 -> 0).
REQ-027 The buffer SHALL present entries in address order; a beat transfers when m_valid && m_ready.
REQ-028 m_data, m_addr and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-029 m_valid SHALL assert in the cycle after the first fetch cycle; first-beat latency is 2 edges after start is sampled.
REQ-030 With m_ready held at 1, the block SHALL deliver one beat per cycle with no bubbles; refetch occurs in the cycle the last buffered entry pops.
REQ-031 m_last SHALL be 1 only on the beat carrying the count-th word.
REQ-032 When all words have been fetched, the FSM SHALL move to DRAIN and stop driving new fetches; raddress outputs hold ptr.
REQ-033 After the m_last handshake the FSM SHALL enter DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
REQ-034 No beat SHALL be dropped or duplicated under any m_ready pattern.

Reset
REQ-035 While reset=0 (asynchronous), the block SHALL force state=IDLE, buffer empty and ptr=0, and drive m_valid, m_last, busy, done, err = 0 and m_data, m_addr, raddress0, raddress1 = 0.
REQ-036 Reset asserted mid-transfer SHALL abandon the transfer immediately with no done pulse; the first start after reset release SHALL be served normally.

Verification
REQ-037 WIDTH=32, N=32, regs r1=0x256 r2=0x23 r3=0x4531 r4=0x4567; start base=1 count=4, m_ready=1 -> beats (1,0x256)(2,0x23)(3,0x4531)(4,0x4567,last) on consecutive cycles, then done pulse.
REQ-038 base=5 count=3 -> beats for addresses 5,6,7 with m_last on 7; the second fetch uses port 0 only.
REQ-039 base=30 count=4 -> addresses 30,31,0,1 in order; WIDTH=64, N=16, base=8, count=16 -> addresses 8..15, 0..7.
REQ-040 Random m_ready (~50%) on count=32 -> all 32 words in order, each exactly once, m_data stable while stalled.
REQ-041 count=0 and count=33 -> one err pulse each, m_valid and busy stay 0; start while busy -> ignored.
REQ-042 reset driven low after 2 beats of count=8 -> m_valid=0 and busy=0 without waiting for a clock edge, no done pulse; reset high, start base=0 count=2 -> 2 correct beats.
